// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for the multicycle RV32I core. Steps each instruction through
//   fetch / decode / execute / memory / writeback, drives the shared datapath
//   mux selects, waits on the memory ready handshake and traps on illegal
//   opcodes.
//
//   Optional feature macro: CTRL_JAL_EN (adds the JAL sequence; without it the
//   JAL opcode traps).
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     op/funct3/funct7     fields from the instruction register
//     zero                 ALU zero flag (beq decision)
//     mem_ready            memory accepted/completed the request this cycle
//     mem_req/mem_write    memory request strobe and store qualifier
//     adr_src              memory address select (0 PC, 1 ALUOut)
//     ir_write/pc_write    instruction register and PC load enables
//     reg_write            register file write enable
//     alu_src_a/alu_src_b  ALU operand selects
//     result_src           result mux select
//     alu_control          ALU operation
//     imm_src              immediate format, decoded directly from op
//     illegal              sticky illegal-instruction flag
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   FETCH     | read instruction at PC, PC+4 into PC when memory is ready
//   DECODE    | register read, branch target (OldPC+imm) into ALUOut
//   MEMADR    | effective address rs1+imm for lw/sw
//   MEMREAD   | load request at ALUOut, wait for ready
//   MEMWB     | write loaded data to rd
//   MEMWRITE  | store request at ALUOut, wait for ready
//   EXECR     | R-type ALU operation rs1 op rs2
//   EXECI     | I-type ALU operation rs1 op imm
//   ALUWB     | write ALUOut to rd
//   BEQ       | compare rs1-rs2, take branch target if zero
//   JAL       | PC <= jump target, ALU forms OldPC+4 for the link
//   TRAP      | illegal opcode seen, frozen until reset
module multicycle_controller #(
  parameter int ALU_CTRL_W   = 3,
  parameter int RESULT_SRC_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic                    adr_src,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [RESULT_SRC_W-1:0] result_src,
  output logic [ALU_CTRL_W-1:0]   alu_control,
  output logic [1:0]              imm_src,
  output logic                    illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  // Per-state control word. The fetch/beq/jal/trap flags let the
  // input-qualified enables avoid a comparison on the state register.
  typedef struct packed {
    logic                    mem_req;
    logic                    mem_write;
    logic                    adr_src;
    logic                    reg_write;
    logic [1:0]              alu_src_a;
    logic [1:0]              alu_src_b;
    logic [1:0]              alu_op;
    logic [RESULT_SRC_W-1:0] result_src;
    logic                    fetch;
    logic                    beq;
    logic                    jal;
    logic                    trap;
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   ctl_q;

  function automatic ctl_t decode_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = RESULT_SRC_W'(2'b10);
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RESULT_SRC_W'(2'b01);
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.beq       = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.jal       = 1'b1;
      end
      S_TRAP:  c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef CTRL_JAL_EN
          OP_JAL:       state_nxt = S_JAL;
`endif
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so outputs come straight
  // from flops; it always equals decode_ctl(state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctl_q <= decode_ctl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctl_q <= decode_ctl(state_nxt);
    end
  end

  // Enables are additionally qualified by rst_n so they drop the instant
  // reset asserts, while the FETCH request reappears as soon as it releases.
  // ir_write/pc_write/beq use the same-cycle handshake and zero flag.
  assign mem_req    = rst_n & ctl_q.mem_req;
  assign mem_write  = rst_n & ctl_q.mem_write;
  assign adr_src    = ctl_q.adr_src;
  assign reg_write  = rst_n & ctl_q.reg_write;
  assign ir_write   = rst_n & ctl_q.fetch & mem_ready;
  assign pc_write   = rst_n & ((ctl_q.fetch & mem_ready) | (ctl_q.beq & zero) | ctl_q.jal);
  assign illegal    = rst_n & ctl_q.trap;
  assign alu_src_a  = ctl_q.alu_src_a;
  assign alu_src_b  = ctl_q.alu_src_b;
  assign result_src = ctl_q.result_src;

  always_comb begin
    alu_control = ALU_CTRL_W'(3'b000);
    case (ctl_q.alu_op)
      2'b01: alu_control = ALU_CTRL_W'(3'b001);
      2'b10: begin
        case (funct3)
          // op[5] separates R-type (sub allowed) from addi
          3'b000:  alu_control = (op[5] & funct7[5]) ? ALU_CTRL_W'(3'b001)
                                                     : ALU_CTRL_W'(3'b000);
          3'b010:  alu_control = ALU_CTRL_W'(3'b101);
          3'b110:  alu_control = ALU_CTRL_W'(3'b011);
          3'b111:  alu_control = ALU_CTRL_W'(3'b010);
          default: alu_control = ALU_CTRL_W'(3'b000);
        endcase
      end
      default: alu_control = ALU_CTRL_W'(3'b000);
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal)
  );

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
  //  alu_src_a, alu_src_b, result_src, alu_control, imm_src}
  logic [17:0] dut_v;
  assign dut_v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
                  alu_src_a, alu_src_b, result_src, alu_control, imm_src};

  typedef enum {K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
                K_EXECR, K_EXECI, K_ALUWB, K_BEQ, K_JAL, K_TRAP} step_t;

  step_t seq[$];

  function automatic logic [2:0] alu_ref(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
    if (f3 == 3'b000) return (o[5] && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [1:0] imm_ref(logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [17:0] exp_vec(step_t k, logic rdy, logic z,
                                          logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
    logic mr = 0, mw = 0, ad = 0, ir = 0, pc = 0, rw = 0, il = 0;
    logic [1:0] a = 0, b = 0, rs = 0;
    logic [2:0] alu = 0;
    case (k)
      K_FETCH:    begin mr = 1; ir = rdy; pc = rdy; b = 2; rs = 2; end
      K_DECODE:   begin a = 1; b = 1; end
      K_MEMADR:   begin a = 2; b = 1; end
      K_MEMREAD:  begin mr = 1; ad = 1; end
      K_MEMWB:    begin rs = 1; rw = 1; end
      K_MEMWRITE: begin mr = 1; mw = 1; ad = 1; end
      K_EXECR:    begin a = 2; b = 0; alu = alu_ref(o, f3, f7); end
      K_EXECI:    begin a = 2; b = 1; alu = alu_ref(o, f3, f7); end
      K_ALUWB:    rw = 1;
      K_BEQ:      begin a = 2; alu = 3'b001; pc = z; end
      K_JAL:      begin a = 1; b = 2; pc = 1; end
      K_TRAP:     il = 1;
      default:    ;
    endcase
    return {mr, mw, ad, ir, pc, rw, il, a, b, rs, alu, imm_ref(o)};
  endfunction

  function automatic void build_seq(logic [6:0] o);
    seq.delete();
    seq.push_back(K_FETCH);
    seq.push_back(K_DECODE);
    if (o == OP_LW) begin
      seq.push_back(K_MEMADR); seq.push_back(K_MEMREAD); seq.push_back(K_MEMWB);
    end else if (o == OP_SW) begin
      seq.push_back(K_MEMADR); seq.push_back(K_MEMWRITE);
    end else if (o == OP_R) begin
      seq.push_back(K_EXECR); seq.push_back(K_ALUWB);
    end else if (o == OP_I) begin
      seq.push_back(K_EXECI); seq.push_back(K_ALUWB);
    end else if (o == OP_BEQ) begin
      seq.push_back(K_BEQ);
`ifdef CTRL_JAL_EN
    end else if (o == OP_JAL) begin
      seq.push_back(K_JAL); seq.push_back(K_ALUWB);
`endif
    end else begin
      seq.push_back(K_TRAP);
    end
  endfunction

  // Runs one instruction from FETCH, checking every cycle. stall<0 gives
  // random ready timing; stall>=0 makes fetch ready at once and the memory
  // step wait exactly 'stall' cycles. zmode<0 randomises the zero flag.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int stall, input int zmode, input string name);
    int idx = 0;
    int st  = 0;
    int cyc = 0;
    logic rdy, z;
    step_t k;
    build_seq(o);
    op = o; funct3 = f3; funct7 = f7;
    while (idx < seq.size()) begin
      k = seq[idx];
      if (k == K_FETCH)
        rdy = (stall < 0) ? (st >= 8 || $urandom_range(0, 2) != 0) : 1'b1;
      else if (k == K_MEMREAD || k == K_MEMWRITE)
        rdy = (stall < 0) ? (st >= 8 || $urandom_range(0, 2) != 0) : (st >= stall);
      else
        rdy = $urandom_range(0, 1);
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      mem_ready = rdy;
      zero = z;
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec(k, rdy, z, o, f3, f7)) begin
        n_fail++;
        $display("FAIL %s step %0d (%s): got %h expected %h", name, cyc, k.name(),
                 dut_v, exp_vec(k, rdy, z, o, f3, f7));
      end
      @(posedge clk); #1;
      if ((k == K_FETCH || k == K_MEMREAD || k == K_MEMWRITE) && !rdy) st++;
      else begin idx++; st = 0; end
      cyc++;
      if (cyc > 100) begin
        n_checks++; n_fail++;
        $display("FAIL %s cycle budget exceeded: got %0d cycles required <=100", name, cyc);
        break;
      end
    end
  endtask

  // Asserts reset from wherever the bench is, checks enables drop at once,
  // then releases and checks the FETCH outputs appear.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write, illegal} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s enables in reset: got %b expected 000000", name,
               {mem_req, mem_write, ir_write, pc_write, reg_write, illegal});
    end
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write, illegal} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s enables held in reset: got %b expected 000000", name,
               {mem_req, mem_write, ir_write, pc_write, reg_write, illegal});
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut_v !== exp_vec(K_FETCH, 1'b0, zero, op, funct3, funct7)) begin
      n_fail++;
      $display("FAIL %s post-release fetch: got %h expected %h", name, dut_v,
               exp_vec(K_FETCH, 1'b0, zero, op, funct3, funct7));
    end
    @(posedge clk); #1;
  endtask

  task automatic hold_trap(input string name);
    for (int i = 0; i < 10; i++) begin
      mem_ready = $urandom_range(0, 1);
      zero = $urandom_range(0, 1);
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec(K_TRAP, mem_ready, zero, op, funct3, funct7)) begin
        n_fail++;
        $display("FAIL %s trap hold cycle %0d: got %h expected %h", name, i, dut_v,
                 exp_vec(K_TRAP, mem_ready, zero, op, funct3, funct7));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    op = OP_LW; funct3 = 3'b000; funct7 = 7'b0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset("reset");
  endtask

  task automatic test_reset_mid_memwrite();
    op = OP_SW; funct3 = 3'b010; funct7 = 7'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (dut_v !== exp_vec(K_MEMWRITE, 1'b0, zero, op, funct3, funct7)) begin
      n_fail++;
      $display("FAIL reset_mid_sw reached memwrite: got %h expected %h", dut_v,
               exp_vec(K_MEMWRITE, 1'b0, zero, op, funct3, funct7));
    end
    #1;
    do_reset("reset_mid_sw");
    run_instr(OP_LW, 3'b010, 7'b0, 0, -1, "lw_after_reset");
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 3'($urandom), 7'($urandom), 0, -1, "lw_ready");
  endtask

  task automatic test_sw_stall();
    run_instr(OP_SW, 3'b010, 7'b0, 3, -1, "sw_stall3");
  endtask

  task automatic test_alu_decode();
    run_instr(OP_R, 3'b000, 7'b0100000, 0, -1, "r_sub");
    run_instr(OP_R, 3'b000, 7'b0000000, 0, -1, "r_add");
    run_instr(OP_R, 3'b111, 7'b0000000, 0, -1, "r_and");
    run_instr(OP_R, 3'b110, 7'b0000000, 0, -1, "r_or");
    run_instr(OP_R, 3'b010, 7'b0000000, 0, -1, "r_slt");
    run_instr(OP_R, 3'b001, 7'b0100000, 0, -1, "r_other");
    run_instr(OP_I, 3'b000, 7'b0100000, 0, -1, "addi_f7");
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 3'b000, 7'b0, 0, 1, "beq_taken");
    run_instr(OP_BEQ, 3'b000, 7'b0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_trap();
    run_instr(7'b1111111, 3'($urandom), 7'($urandom), -1, -1, "trap_ff");
    hold_trap("trap_ff");
    do_reset("trap_ff_reset");
    run_instr(OP_JAL, 3'($urandom), 7'($urandom), -1, -1, "jal");
`ifndef CTRL_JAL_EN
    hold_trap("jal_trap");
    do_reset("jal_trap_reset");
`endif
  endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_R};
    logic [6:0] o;
    logic [6:0] f7;
    for (int i = 0; i < 200; i++) begin
      o  = ops[$urandom_range(0, 5)];
      f7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'($urandom);
      run_instr(o, 3'($urandom), f7, -1, -1, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_decode();
    test_beq();
    test_reset_mid_memwrite();
    test_random();
    test_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
